// File: rtl/mem_stage.sv
// Memory-access stage: EXE->MEM register, load/store sequencing against a
// synchronous data RAM, MEM->WB bus and forwarding outputs.
module mem_stage #(
    parameter int DM_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         EXE_over,
    input  logic [153:0] EXE_MEM_bus,
    input  logic         WB_allow_in,
    input  logic [31:0]  dm_rdata,
    output logic         MEM_allow_in,
    output logic         MEM_valid,
    output logic         MEM_over,
    output logic [117:0] MEM_WB_bus,
    output logic [31:0]  dm_addr,
    output logic [3:0]   dm_wen,
    output logic [31:0]  dm_wdata,
    output logic [4:0]   MEM_wdest,
    output logic [31:0]  MEM_result,
    output logic [31:0]  MEM_pc
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t         state;
    logic           valid;
    logic           st_done;
    logic [1:0]     cnt;
    logic [153:0]   bus_r;
    logic [31:0]    ld_r;

    logic           load, store, ls_word, lb_sign;
    logic [31:0]    store_data, exe_result, lo_result, pc;
    logic [15:0]    misc;
    logic           rf_wen;
    logic [4:0]     rf_wdest;
    logic [7:0]     ld_byte;
    logic [31:0]    ld_data;
    logic [31:0]    mem_result;
    logic [3:0]     wen;

    assign {load, store, ls_word, lb_sign} = bus_r[153:150];
    assign store_data = bus_r[149:118];
    assign exe_result = bus_r[117:86];
    assign lo_result  = bus_r[85:54];
    assign misc       = bus_r[53:38];
    assign rf_wen     = bus_r[37];
    assign rf_wdest   = bus_r[36:32];
    assign pc         = bus_r[31:0];

    always_comb begin
        ld_byte = dm_rdata[7:0];
        unique case (exe_result[1:0])
            2'd0: ld_byte = dm_rdata[7:0];
            2'd1: ld_byte = dm_rdata[15:8];
            2'd2: ld_byte = dm_rdata[23:16];
            2'd3: ld_byte = dm_rdata[31:24];
            default: ld_byte = dm_rdata[7:0];
        endcase
        ld_data = ls_word ? dm_rdata
                          : {{24{lb_sign & ld_byte[7]}}, ld_byte};
    end

    // A store drives its enables only until the first write has happened.
    always_comb begin
        wen = 4'b0000;
        if (valid && store && !st_done)
            wen = ls_word ? 4'b1111 : 4'b0001 << exe_result[1:0];
    end

    always_comb begin
        MEM_over = 1'b0;
        if (valid) begin
            if (load)
                MEM_over = (state == DONE);
            else if (store)
                MEM_over = st_done | (wen != 4'b0000);
            else
                MEM_over = 1'b1;
        end
    end

    assign MEM_allow_in = ~valid | (MEM_over & WB_allow_in);
    assign mem_result   = load ? ld_r : exe_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            state   <= IDLE;
            cnt     <= 2'd0;
            st_done <= 1'b0;
        end else if (MEM_allow_in) begin
            valid   <= EXE_over;
            if (EXE_over)
                bus_r <= EXE_MEM_bus;
            state   <= IDLE;
            cnt     <= 2'd0;
            st_done <= 1'b0;
        end else begin
            if (wen != 4'b0000)
                st_done <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (valid && load) begin
                        state <= WAIT;
                        cnt   <= 2'd1;
                    end
                end
                WAIT: begin
                    if (cnt == 2'(DM_LATENCY)) begin
                        state <= DONE;
                        ld_r  <= ld_data;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign MEM_valid  = valid;
    assign dm_wen     = wen;
    assign dm_addr    = valid ? {exe_result[31:2], 2'b00} : 32'd0;
    assign dm_wdata   = (valid && store)
                      ? (ls_word ? store_data : {4{store_data[7:0]}})
                      : 32'd0;
    assign MEM_wdest  = rf_wdest & {5{valid}};
    assign MEM_pc     = valid ? pc : 32'd0;
    assign MEM_result = valid ? mem_result : 32'd0;
    assign MEM_WB_bus = valid
                      ? {rf_wen, rf_wdest, mem_result, lo_result, misc, pc}
                      : 118'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then random traffic, all checked
// against a transaction-level model of stage residency and RAM contents.
module tb_mem_stage;

    localparam int LAT = 3;

    localparam logic [3:0] C_ALU = 4'b0000;
    localparam logic [3:0] C_LW  = 4'b1010;
    localparam logic [3:0] C_LB  = 4'b1001;
    localparam logic [3:0] C_LBU = 4'b1000;
    localparam logic [3:0] C_SW  = 4'b0110;
    localparam logic [3:0] C_SB  = 4'b0100;

    logic         clk = 1'b0;
    logic         rst;
    logic         EXE_over;
    logic [153:0] EXE_MEM_bus;
    logic         WB_allow_in;
    logic [31:0]  dm_rdata;
    logic         MEM_allow_in, MEM_valid, MEM_over;
    logic [117:0] MEM_WB_bus;
    logic [31:0]  dm_addr, dm_wdata, MEM_result, MEM_pc;
    logic [3:0]   dm_wen;
    logic [4:0]   MEM_wdest;

    mem_stage #(.DM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .EXE_over(EXE_over),
        .EXE_MEM_bus(EXE_MEM_bus), .WB_allow_in(WB_allow_in),
        .dm_rdata(dm_rdata), .MEM_allow_in(MEM_allow_in),
        .MEM_valid(MEM_valid), .MEM_over(MEM_over),
        .MEM_WB_bus(MEM_WB_bus), .dm_addr(dm_addr), .dm_wen(dm_wen),
        .dm_wdata(dm_wdata), .MEM_wdest(MEM_wdest),
        .MEM_result(MEM_result), .MEM_pc(MEM_pc)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [64];
    logic [5:0]  apipe [LAT];
    assign dm_rdata = ram[apipe[LAT-1]];

    int tests = 0;
    int failed = 0;

    logic         m_valid;
    logic [153:0] m_bus;
    int           m_age;

    logic        s_over, s_allow, s_valid;
    logic [3:0]  s_wen;
    logic [31:0] s_res, s_wdata, s_pc, s_addr;

    function automatic logic [31:0] align(logic [31:0] w, logic [1:0] a,
                                          logic word, logic sgn);
        logic [7:0] by;
        if (word) return w;
        by = 8'(w >> (8 * a));
        return sgn ? 32'(int'($signed(by))) : 32'(by);
    endfunction

    function automatic logic [153:0] mk(logic [3:0] ctl, logic [31:0] sd,
                                        logic [31:0] ex, logic [31:0] pc);
        return {ctl, sd, ex, 32'($urandom), 6'($urandom), 8'($urandom),
                2'($urandom), 1'($urandom), 5'($urandom), pc};
    endfunction

    function automatic logic [153:0] rand_instr();
        logic [3:0] c;
        case ($urandom_range(0, 5))
            0: c = C_ALU;
            1: c = C_LW;
            2: c = C_LB;
            3: c = C_LBU;
            4: c = C_SW;
            default: c = C_SB;
        endcase
        return mk(c, $urandom, $urandom, $urandom);
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance model and RAM.
    task automatic step(input logic eo, input logic [153:0] b,
                        input logic wa, input logic r);
        logic [3:0]   ctl, e_wen;
        logic [31:0]  ex, sd, mres, e_wdata;
        logic         e_over, e_allow;
        logic [117:0] e_bus;
        rst = r;
        EXE_over = eo;
        EXE_MEM_bus = b;
        WB_allow_in = wa;
        #1;
        ctl = m_bus[153:150];
        sd = m_bus[149:118];
        ex = m_bus[117:86];
        e_over = m_valid && (ctl[3] ? (m_age >= LAT + 1) : 1'b1);
        e_allow = !m_valid || (e_over && wa);
        e_wen = (m_valid && ctl[2] && m_age == 0)
              ? (ctl[1] ? 4'hf : 4'(1 << ex[1:0])) : 4'h0;
        e_wdata = ctl[1] ? sd : {4{sd[7:0]}};
        mres = ctl[3] ? align(ram[ex[7:2]], ex[1:0], ctl[1], ctl[0]) : ex;
        e_bus = {m_bus[37], m_bus[36:32], mres, m_bus[85:54],
                 m_bus[53:38], m_bus[31:0]};
        chk("allow_in", MEM_allow_in, e_allow);
        chk("valid", MEM_valid, m_valid);
        chk("over", MEM_over, e_over);
        chk("dm_wen", dm_wen, e_wen);
        chk("wdest", MEM_wdest, m_valid ? m_bus[36:32] : 5'd0);
        chk("pc", MEM_pc, m_valid ? m_bus[31:0] : 32'd0);
        chk("dm_addr", dm_addr, m_valid ? {ex[31:2], 2'b00} : 32'd0);
        if (e_wen != 4'h0)
            chk("dm_wdata", dm_wdata, e_wdata);
        if (e_over) begin
            chk("wb_bus", MEM_WB_bus, e_bus);
            chk("result", MEM_result, mres);
        end else if (!m_valid) begin
            chk("wb_bus_idle", MEM_WB_bus, 0);
            chk("wdata_idle", dm_wdata, 0);
        end
        s_over = MEM_over;
        s_allow = MEM_allow_in;
        s_valid = MEM_valid;
        s_wen = dm_wen;
        s_res = MEM_result;
        s_wdata = dm_wdata;
        s_pc = MEM_pc;
        s_addr = dm_addr;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
        end else if (e_allow) begin
            m_valid = eo;
            if (eo) m_bus = b;
            m_age = 0;
        end else begin
            m_age++;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (s_wen[i]) ram[s_addr[7:2]][8*i +: 8] = s_wdata[8*i +: 8];
        for (int i = LAT - 1; i > 0; i--) apipe[i] = apipe[i-1];
        apipe[0] = s_addr[7:2];
    endtask

    initial begin
        int n;
        logic [3:0] extra;
        logic [31:0] w5;
        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        for (int i = 0; i < LAT; i++) apipe[i] = 6'd0;
        m_valid = 1'b0;
        m_bus = '0;
        m_age = 0;
        rst = 1'b1;
        EXE_over = 1'b0;
        EXE_MEM_bus = '0;
        WB_allow_in = 1'b1;
        repeat (2) @(negedge clk);

        // reset state
        step(1'b1, rand_instr(), 1'b1, 1'b1);
        chk("t1_valid", s_valid, 1'b0);
        chk("t1_allow", s_allow, 1'b1);
        chk("t1_wen", s_wen, 4'h0);

        // lb sign-extend, then lbu
        ram[0] = 32'h80FF7F01;
        step(1'b1, mk(C_LB, $urandom, 32'h102, 32'h400), 1'b1, 1'b0);
        n = 0;
        s_over = 1'b0;
        while (!s_over && n < 12) begin
            step(1'b0, rand_instr(), 1'b1, 1'b0);
            if (!s_over) n++;
        end
        chk("t2_lat", n, LAT + 1);
        chk("t2_lb", s_res, 32'hFFFFFFFF);
        step(1'b1, mk(C_LBU, $urandom, 32'h103, 32'h404), 1'b1, 1'b0);
        n = 0;
        s_over = 1'b0;
        while (!s_over && n < 12) begin
            step(1'b0, rand_instr(), 1'b1, 1'b0);
            if (!s_over) n++;
        end
        chk("t2_lbu", s_res, 32'h00000080);

        // sb under WB stall writes once
        step(1'b1, mk(C_SB, 32'h123456AB, 32'h201, 32'h500), 1'b1, 1'b0);
        step(1'b0, rand_instr(), 1'b0, 1'b0);
        chk("t3_wen", s_wen, 4'b0010);
        chk("t3_wdata", s_wdata, 32'hABABABAB);
        extra = 4'h0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, rand_instr(), 1'b0, 1'b0);
            extra |= s_wen;
        end
        step(1'b0, rand_instr(), 1'b1, 1'b0);
        extra |= s_wen;
        chk("t3_nowrite", extra, 4'h0);
        chk("t3_over", s_over, 1'b1);

        // back-to-back
        step(1'b1, mk(C_ALU, $urandom, $urandom, 32'h1000), 1'b1, 1'b0);
        step(1'b1, mk(C_SW, $urandom, 32'h300, 32'h1004), 1'b1, 1'b0);
        chk("t4_pc0", {s_over, s_pc}, {1'b1, 32'h1000});
        step(1'b1, mk(C_ALU, $urandom, $urandom, 32'h1008), 1'b1, 1'b0);
        chk("t4_pc1", {s_over, s_pc}, {1'b1, 32'h1004});
        step(1'b0, rand_instr(), 1'b1, 1'b0);
        chk("t4_pc2", {s_over, s_pc}, {1'b1, 32'h1008});

        // lw stall with EXE bus churning
        w5 = $urandom;
        ram[1] = w5;
        step(1'b1, mk(C_LW, $urandom, 32'h104, 32'h2000), 1'b1, 1'b0);
        n = 0;
        s_over = 1'b0;
        while (!s_over && n < 12) begin
            step(1'b1, rand_instr(), 1'b1, 1'b0);
            if (!s_allow) n++;
        end
        chk("t5_stall", n, LAT + 1);
        chk("t5_lw", s_res, w5);
        while (s_valid && !s_over && n < 24) begin
            step(1'b0, rand_instr(), 1'b1, 1'b0);
            n++;
        end
        step(1'b0, rand_instr(), 1'b1, 1'b0);
        step(1'b0, rand_instr(), 1'b1, 1'b0);

        // reset mid-load
        step(1'b1, mk(C_LW, $urandom, 32'h108, 32'h3000), 1'b1, 1'b0);
        step(1'b0, rand_instr(), 1'b1, 1'b0);
        step(1'b0, rand_instr(), 1'b1, 1'b0);
        step(1'b0, rand_instr(), 1'b1, 1'b1);
        extra = 4'h0;
        for (int i = 0; i < LAT + 2; i++) begin
            step(1'b0, rand_instr(), 1'b1, 1'b0);
            extra[0] |= s_over | s_valid;
        end
        chk("t6_dropped", extra, 4'h0);

        // random traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, rand_instr(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 96) == 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
